// File: rtl/pc_exception_unit_pkg.sv
// rtl/pc_exception_unit_pkg.sv - shared codes and default vectors for the PC/exception unit
package pc_exception_unit_pkg;

  localparam logic [2:0] PCSRC_ALU    = 3'd0;
  localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
  localparam logic [2:0] PCSRC_REG    = 3'd2;
  localparam logic [2:0] PCSRC_JUMP   = 3'd3;

  typedef enum logic [1:0] {
    CAUSE_EXT0  = 2'd0,
    CAUSE_EXT1  = 2'd1,
    CAUSE_SYS   = 2'd2,
    CAUSE_ALIGN = 2'd3
  } cause_e;

  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam logic [15:0] DEF_SYS_VEC  = 16'h0010;
  localparam logic [15:0] DEF_EXC_VEC  = 16'h0020;

endpackage

// File: rtl/pc_exception_unit_perf_counter.sv
// rtl/pc_exception_unit_perf_counter.sv - wrapping performance counter with clear priority
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + ONE;
  end

endmodule

// File: rtl/pc_exception_unit.sv
// rtl/pc_exception_unit.sv - PC, EPC/Cause and perf counters for the 16-bit multicycle datapath
module pc_exception_unit
  import pc_exception_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEF_RESET_PC,
  parameter logic [15:0] SYS_VEC  = DEF_SYS_VEC,
  parameter logic [15:0] EXC_VEC  = DEF_EXC_VEC,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PCWrite,
  input  logic             isBranch,
  input  logic             isBIEQ,
  input  logic [2:0]       PCSrc,
  input  logic             Zero,
  input  logic [15:0]      ALUResult,
  input  logic [15:0]      ALUOut,
  input  logic [15:0]      RegA,
  input  logic [11:0]      JumpImm,
  input  logic             syscall,
  input  logic             EPCWrite,
  input  logic             CauseWrite,
  input  logic             IntCause,
  input  logic             addInstr,
  input  logic             addCycle,
  input  logic             cnt_clr,
  output logic [15:0]      PC,
  output logic [15:0]      EPC,
  output logic [1:0]       Cause,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic             trap_taken
);

  logic [15:0] target;
  logic        takeBranch;
  logic        pcEn;
  logic        excTrap;
  logic        sysTrap;
  logic        alignTrap;

  always_comb begin
    target = ALUResult;
    case (PCSrc)
      PCSRC_ALUOUT: target = ALUOut;
      PCSRC_REG:    target = RegA;
      PCSRC_JUMP:   target = {PC[15:13], JumpImm, 1'b0};
      default:      target = ALUResult;
    endcase
  end

  assign takeBranch = isBranch & (isBIEQ ? Zero : ~Zero);
  assign pcEn       = PCWrite | takeBranch;

  // Trap classes are mutually exclusive so the register block below reads as a flat priority list.
  assign excTrap   = EPCWrite | CauseWrite;
  assign sysTrap   = ~excTrap & syscall & PCWrite;
  assign alignTrap = ~excTrap & ~sysTrap & pcEn & target[0];

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      PC         <= RESET_PC;
      EPC        <= 16'h0000;
      Cause      <= CAUSE_EXT0;
      trap_taken <= 1'b0;
    end else begin
      trap_taken <= excTrap | sysTrap | alignTrap;
      if (excTrap) begin
        if (EPCWrite)
          EPC <= PC;
        if (CauseWrite)
          Cause <= IntCause ? CAUSE_EXT1 : CAUSE_EXT0;
        PC <= EXC_VEC;
      end else if (sysTrap) begin
        EPC   <= ALUResult;
        Cause <= CAUSE_SYS;
        PC    <= SYS_VEC;
      end else if (alignTrap) begin
        EPC   <= PC;
        Cause <= CAUSE_ALIGN;
        PC    <= EXC_VEC;
      end else if (pcEn) begin
        PC <= target;
      end
    end
  end

  perf_counter #(.CNT_W(CNT_W)) uInstrCnt (
    .CLK   (CLK),
    .Reset (Reset),
    .en    (addInstr),
    .clr   (cnt_clr),
    .count (instr_count)
  );

  perf_counter #(.CNT_W(CNT_W)) uCycleCnt (
    .CLK   (CLK),
    .Reset (Reset),
    .en    (addCycle),
    .clr   (cnt_clr),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_pc_exception_unit.sv
// tb/tb_pc_exception_unit.sv - self-checking bench for pc_exception_unit
module tb_pc_exception_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWrite, isBranch, isBIEQ, Zero;
  logic [2:0]  PCSrc;
  logic [15:0] ALUResult, ALUOut, RegA;
  logic [11:0] JumpImm;
  logic        syscall, EPCWrite, CauseWrite, IntCause;
  logic        addInstr, addCycle, cnt_clr;

  logic [15:0] PC, EPC, PCs, EPCs;
  logic [1:0]  Cause, Causes;
  logic [31:0] instr_count, cycle_count;
  logic [7:0]  instr_count8, cycle_count8;
  logic        trap_taken, trap_taken8;

  int checks = 0;
  int errors = 0;

  logic [15:0] mPC, mEPC;
  logic [1:0]  mCause;
  logic [31:0] mInstr, mCycle;
  logic [7:0]  mInstr8, mCycle8;
  logic        mTrap;

  always #5 CLK = ~CLK;

  pc_exception_unit dut (
    .CLK(CLK), .Reset(Reset), .PCWrite(PCWrite), .isBranch(isBranch), .isBIEQ(isBIEQ),
    .PCSrc(PCSrc), .Zero(Zero), .ALUResult(ALUResult), .ALUOut(ALUOut), .RegA(RegA),
    .JumpImm(JumpImm), .syscall(syscall), .EPCWrite(EPCWrite), .CauseWrite(CauseWrite),
    .IntCause(IntCause), .addInstr(addInstr), .addCycle(addCycle), .cnt_clr(cnt_clr),
    .PC(PC), .EPC(EPC), .Cause(Cause), .instr_count(instr_count), .cycle_count(cycle_count),
    .trap_taken(trap_taken)
  );

  // Narrow-counter copy so the all-ones wrap can be reached in a few hundred cycles.
  pc_exception_unit #(.CNT_W(8)) dut8 (
    .CLK(CLK), .Reset(Reset), .PCWrite(PCWrite), .isBranch(isBranch), .isBIEQ(isBIEQ),
    .PCSrc(PCSrc), .Zero(Zero), .ALUResult(ALUResult), .ALUOut(ALUOut), .RegA(RegA),
    .JumpImm(JumpImm), .syscall(syscall), .EPCWrite(EPCWrite), .CauseWrite(CauseWrite),
    .IntCause(IntCause), .addInstr(addInstr), .addCycle(addCycle), .cnt_clr(cnt_clr),
    .PC(PCs), .EPC(EPCs), .Cause(Causes), .instr_count(instr_count8), .cycle_count(cycle_count8),
    .trap_taken(trap_taken8)
  );

  task automatic idleInputs();
    PCWrite = 0; isBranch = 0; isBIEQ = 0; Zero = 0; PCSrc = 0;
    ALUResult = 0; ALUOut = 0; RegA = 0; JumpImm = 0;
    syscall = 0; EPCWrite = 0; CauseWrite = 0; IntCause = 0;
    addInstr = 0; addCycle = 0; cnt_clr = 0;
  endtask

  task automatic modelReset();
    mPC = 16'h0000; mEPC = 0; mCause = 0; mInstr = 0; mCycle = 0;
    mInstr8 = 0; mCycle8 = 0; mTrap = 0;
  endtask

  task automatic modelStep();
    logic [15:0] tgt;
    bit jump;
    case (PCSrc)
      3'd1:    tgt = ALUOut;
      3'd2:    tgt = RegA;
      3'd3:    tgt = {mPC[15:13], JumpImm, 1'b0};
      default: tgt = ALUResult;
    endcase
    jump = PCWrite || (isBranch && (isBIEQ ? Zero : !Zero));
    mTrap = 1'b1;
    if (EPCWrite || CauseWrite) begin
      if (EPCWrite) mEPC = mPC;
      if (CauseWrite) mCause = IntCause ? 2'd1 : 2'd0;
      mPC = 16'h0020;
    end else if (syscall && PCWrite) begin
      mEPC = ALUResult; mCause = 2'd2; mPC = 16'h0010;
    end else if (jump && (tgt % 2 == 1)) begin
      mEPC = mPC; mCause = 2'd3; mPC = 16'h0020;
    end else begin
      mTrap = 1'b0;
      if (jump) mPC = tgt;
    end
    if (cnt_clr) begin
      mInstr = 0; mCycle = 0; mInstr8 = 0; mCycle8 = 0;
    end else begin
      if (addInstr) begin mInstr = mInstr + 1; mInstr8 = mInstr8 + 1; end
      if (addCycle) begin mCycle = mCycle + 1; mCycle8 = mCycle8 + 1; end
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge CLK);
    #1;
  endtask

  task automatic setPc(input logic [15:0] v);
    idleInputs();
    PCWrite = 1; ALUResult = v;
    tick();
    idleInputs();
  endtask

  task automatic test_reset();
    idleInputs();
    Reset = 1;
    modelReset();
    @(posedge CLK); #1;
    Reset = 0;
    setPc(16'h1234);
    addInstr = 1; addCycle = 1; EPCWrite = 1; CauseWrite = 1; IntCause = 1;
    tick();
    idleInputs();
    #2;
    Reset = 1;
    modelReset();
    #1;
    checks++;
    if (PC !== 16'h0000 || EPC !== 16'h0000 || Cause !== 2'd0 || trap_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs PC=%h EPC=%h Cause=%0d trap=%b expected 0000 0000 0 0", PC, EPC, Cause, trap_taken);
    end
    checks++;
    if (instr_count !== 32'd0 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters instr=%0d cycle=%0d expected 0 0", instr_count, cycle_count);
    end
    @(posedge CLK); #1;
    Reset = 0;
  endtask

  task automatic test_fetch();
    idleInputs();
    PCWrite = 1; PCSrc = 0; ALUResult = 16'h0002; addInstr = 1; addCycle = 1;
    tick();
    checks++;
    if (PC !== 16'h0002 || instr_count !== 32'd1 || cycle_count !== 32'd1) begin
      errors++;
      $display("FAIL fetch PC=%h instr=%0d cycle=%0d expected 0002 1 1", PC, instr_count, cycle_count);
    end
    idleInputs();
    addCycle = 1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (PC !== 16'h0002 || cycle_count !== 32'd4 || instr_count !== 32'd1) begin
      errors++;
      $display("FAIL cycle_count PC=%h cycle=%0d instr=%0d expected 0002 4 1", PC, cycle_count, instr_count);
    end
    idleInputs();
    syscall = 1; ALUResult = 16'h0008;
    tick();
    checks++;
    if (PC !== 16'h0002 || Cause !== 2'd0 || trap_taken !== 1'b0) begin
      errors++;
      $display("FAIL syscall_no_pcwrite PC=%h Cause=%0d trap=%b expected 0002 0 0", PC, Cause, trap_taken);
    end
  endtask

  task automatic test_branch();
    setPc(16'h0100);
    isBranch = 1; isBIEQ = 1; Zero = 1; PCSrc = 1; ALUOut = 16'h0040;
    tick();
    checks++;
    if (PC !== 16'h0040) begin
      errors++;
      $display("FAIL beq_taken PC=%h expected 0040", PC);
    end
    setPc(16'h0100);
    isBranch = 1; isBIEQ = 0; Zero = 1; PCSrc = 1; ALUOut = 16'h0040;
    tick();
    checks++;
    if (PC !== 16'h0100) begin
      errors++;
      $display("FAIL bne_not_taken PC=%h expected 0100", PC);
    end
    Zero = 0;
    tick();
    checks++;
    if (PC !== 16'h0040) begin
      errors++;
      $display("FAIL bne_taken PC=%h expected 0040", PC);
    end
  endtask

  task automatic test_jump_syscall();
    setPc(16'h6000);
    PCWrite = 1; PCSrc = 3; JumpImm = 12'h123;
    tick();
    checks++;
    if (PC !== 16'h6246 || trap_taken !== 1'b0) begin
      errors++;
      $display("FAIL jump PC=%h trap=%b expected 6246 0", PC, trap_taken);
    end
    idleInputs();
    syscall = 1; PCWrite = 1; ALUResult = 16'h6248;
    tick();
    checks++;
    if (PC !== 16'h0010 || EPC !== 16'h6248 || Cause !== 2'd2 || trap_taken !== 1'b1) begin
      errors++;
      $display("FAIL syscall PC=%h EPC=%h Cause=%0d trap=%b expected 0010 6248 2 1", PC, EPC, Cause, trap_taken);
    end
    idleInputs();
    tick();
    checks++;
    if (trap_taken !== 1'b0 || PC !== 16'h0010) begin
      errors++;
      $display("FAIL trap_pulse trap=%b PC=%h expected 0 0010", trap_taken, PC);
    end
  endtask

  task automatic test_misaligned();
    setPc(16'h0200);
    PCSrc = 2; RegA = 16'h0101; PCWrite = 1;
    tick();
    checks++;
    if (PC !== 16'h0020 || EPC !== 16'h0200 || Cause !== 2'd3 || trap_taken !== 1'b1) begin
      errors++;
      $display("FAIL misaligned PC=%h EPC=%h Cause=%0d trap=%b expected 0020 0200 3 1", PC, EPC, Cause, trap_taken);
    end
  endtask

  task automatic test_simultaneous();
    setPc(16'h0300);
    EPCWrite = 1; CauseWrite = 1; IntCause = 1; PCWrite = 1; syscall = 1; ALUResult = 16'h0400;
    tick();
    checks++;
    if (PC !== 16'h0020 || EPC !== 16'h0300 || Cause !== 2'd1 || trap_taken !== 1'b1) begin
      errors++;
      $display("FAIL exception_priority PC=%h EPC=%h Cause=%0d trap=%b expected 0020 0300 1 1", PC, EPC, Cause, trap_taken);
    end
    idleInputs();
    addInstr = 1;
    tick();
    cnt_clr = 1; addCycle = 1;
    tick();
    checks++;
    if (instr_count !== 32'd0 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL clr_priority instr=%0d cycle=%0d expected 0 0", instr_count, cycle_count);
    end
  endtask

  task automatic test_wrap();
    idleInputs();
    cnt_clr = 1;
    tick();
    idleInputs();
    addInstr = 1;
    for (int i = 0; i < 255; i++) tick();
    checks++;
    if (instr_count8 !== 8'hFF || instr_count !== 32'd255) begin
      errors++;
      $display("FAIL wrap_pre instr8=%h instr=%0d expected ff 255", instr_count8, instr_count);
    end
    tick();
    checks++;
    if (instr_count8 !== 8'h00 || instr_count !== 32'd256) begin
      errors++;
      $display("FAIL wrap instr8=%h instr=%0d expected 00 256", instr_count8, instr_count);
    end
    idleInputs();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      idleInputs();
      PCWrite    = ($urandom_range(0, 2) == 0);
      isBranch   = ($urandom_range(0, 2) == 0);
      isBIEQ     = $urandom_range(0, 1);
      Zero       = $urandom_range(0, 1);
      PCSrc      = 3'($urandom_range(0, 7));
      ALUResult  = 16'($urandom);
      ALUOut     = 16'($urandom);
      RegA       = 16'($urandom);
      JumpImm    = 12'($urandom);
      syscall    = ($urandom_range(0, 7) == 0);
      EPCWrite   = ($urandom_range(0, 11) == 0);
      CauseWrite = ($urandom_range(0, 11) == 0);
      IntCause   = $urandom_range(0, 1);
      addInstr   = $urandom_range(0, 1);
      addCycle   = ($urandom_range(0, 3) != 0);
      cnt_clr    = ($urandom_range(0, 31) == 0);
      tick();
      checks++;
      if (PC !== mPC || EPC !== mEPC || Cause !== mCause || trap_taken !== mTrap ||
          instr_count !== mInstr || cycle_count !== mCycle ||
          instr_count8 !== mInstr8 || cycle_count8 !== mCycle8) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL random[%0d] PC=%h/%h EPC=%h/%h Cause=%0d/%0d trap=%b/%b instr=%0d/%0d cycle=%0d/%0d (got/expected)",
                   i, PC, mPC, EPC, mEPC, Cause, mCause, trap_taken, mTrap,
                   instr_count, mInstr, cycle_count, mCycle);
      end
    end
    idleInputs();
  endtask

  initial begin
    idleInputs();
    Reset = 1;
    modelReset();
    test_reset();
    test_fetch();
    test_branch();
    test_jump_syscall();
    test_misaligned();
    test_simultaneous();
    test_wrap();
    test_random();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_exception_unit.md
Name: pc_exception_unit

Overview:
- Owns the program counter, EPC and Cause registers, and the instruction and cycle performance counters of the 16-bit multicycle datapath.
- Sits directly downstream of the multicycle control FSM and consumes its PCWrite, isBranch, isBIEQ, PCSrc, syscall, EPCWrite, CauseWrite, IntCause, addInstr and addCycle strobes.
- Resolves branches, selects the next PC and redirects to trap vectors.
- Drives PC to the memory address mux and to ALU source A.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- SYS_VEC, 16'h0010, syscall handler address.
- EXC_VEC, 16'h0020, exception handler address.
- CNT_W, 32, width of each performance counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PCWrite  in  1  unconditional PC update strobe.
- isBranch  in  1  conditional PC update strobe.
- isBIEQ  in  1  1 = branch on Zero, 0 = branch on !Zero.
- PCSrc  in  3  next-PC select: 0 ALUResult, 1 ALUOut, 2 RegA, 3 {PC[15:13], JumpImm, 1'b0}.
- Zero  in  1  ALU zero flag of the current cycle.
- ALUResult  in  16  combinational ALU output (PC+2 during Fetch).
- ALUOut  in  16  registered ALU output (branch target computed in Decode).
- RegA  in  16  register-file read port A (JumpReg target).
- JumpImm  in  12  instruction jump field.
- syscall  in  1  syscall trap request.
- EPCWrite  in  1  exception trap: EPC write request.
- CauseWrite  in  1  exception trap: Cause write request.
- IntCause  in  1  exception source bit.
- addInstr  in  1  instruction counter increment.
- addCycle  in  1  cycle counter increment.
- cnt_clr  in  1  synchronous clear of both counters.
- PC  out  16  current PC.
- EPC  out  16  exception return address.
- Cause  out  2  trap code: 0 ext/IntCause=0, 1 IntCause=1, 2 syscall, 3 misaligned target.
- instr_count  out  CNT_W  retired-fetch count.
- cycle_count  out  CNT_W  cycle count.
- trap_taken  out  1  registered one-cycle pulse in the cycle after any trap redirect.

Behaviour:
- Reset values: PC = RESET_PC; EPC = 0; Cause = 0; instr_count = 0; cycle_count = 0; trap_taken = 0.
- target = mux(PCSrc) as listed; PCSrc codes 4-7 select ALUResult.
- take_branch = isBranch & (isBIEQ ? Zero : !Zero).
- pc_en = PCWrite | take_branch.
- Priority per cycle, highest first; exactly one case applies:
  1. Exception: EPCWrite | CauseWrite.
     - If EPCWrite: EPC <= PC.
     - If CauseWrite: Cause <= {1'b0, IntCause}.
     - PC <= EXC_VEC. Concurrent pc_en and syscall are ignored.
  2. Syscall: syscall & PCWrite.
     - EPC <= ALUResult (the return address).
     - Cause <= 2.
     - PC <= SYS_VEC.
  3. Misaligned target: pc_en & target[0]. PC is not loaded with target.
     - EPC <= PC.
     - Cause <= 3.
     - PC <= EXC_VEC.
  4. Normal: pc_en: PC <= target.
  5. Otherwise PC holds.
- syscall without PCWrite has no effect.
- Every update takes effect at the next rising edge (1-cycle latency). There is no combinational path from PCSrc to PC.
- trap_taken <= 1 in the cycle following cases 1-3, and 0 otherwise.
- Counters:
  - Each increments by 1 on its enable and wraps from all-ones to 0.
  - cnt_clr has priority over increment in the same cycle; result is 0 that cycle.
  - Counters are independent of traps.
- Reset mid-instruction forces all outputs to reset values immediately, with no clock required. The first edge after deassertion resumes normal operation.

Decomposition:
- Shared package: PCSrc codes (PCSRC_ALU = 0, PCSRC_ALUOUT = 1, PCSRC_REG = 2, PCSRC_JUMP = 3), Cause codes (CAUSE_EXT0 = 0, CAUSE_EXT1 = 1, CAUSE_SYS = 2, CAUSE_ALIGN = 3), default vector constants.
- Sub-module: perf_counter (CNT_W, en, clr, count), instantiated twice.

Test Plan:
- Reset: assert Reset asynchronously mid-cycle -> PC = 0000, EPC = 0, Cause = 0, both counters 0 before the next edge.
- Fetch: PCWrite = 1, PCSrc = 0, ALUResult = 0002, addInstr = 1 -> PC = 0002 and instr_count = 1 after 1 edge; cycle_count increments every edge while addCycle = 1.
- Branch, ALUOut = 0040:
  - isBranch = 1, isBIEQ = 1, Zero = 1 -> PC = 0040.
  - isBIEQ = 0, Zero = 1 -> PC unchanged.
  - isBIEQ = 0, Zero = 0 -> PC = 0040.
- Jump and syscall, PC = 6000:
  - PCSrc = 3, JumpImm = 12'h123, PCWrite = 1 -> PC = 6246.
  - syscall = 1, PCWrite = 1, ALUResult = 6248 -> PC = 0010, EPC = 6248, Cause = 2, trap_taken pulses once.
- Misaligned jump register: PCSrc = 2, RegA = 0101, PCWrite = 1 at PC = 0200 -> PC = 0020, EPC = 0200, Cause = 3.
- Simultaneous events:
  - EPCWrite = CauseWrite = 1, IntCause = 1, together with PCWrite = 1 at PC = 0300 -> EPC = 0300, Cause = 1, PC = 0020.
  - cnt_clr = 1 with addInstr = 1 -> instr_count = 0.
  - instr_count = FFFFFFFF with addInstr = 1 -> instr_count = 0 (wrap).
